// File: rtl/sc_timing_pkg.sv
// rtl/sc_timing_pkg.sv - shared constants and helpers for the sync timing measurement block
// Holds the status word bit map, counter width limits and the stability counter width.
package sc_timing_pkg;

    // Widest counters the status word can carry.
    localparam int SC_H_CNT_W_MAX = 12;
    localparam int SC_V_CNT_W_MAX = 11;

    // Stability counter width; the counter saturates at all-ones (15).
    localparam int SC_STAB_CNT_W = 4;

    // Status word bit map.
    localparam int SC_ST_H_LSB         = 0;
    localparam int SC_ST_H_MSB         = 11;
    localparam int SC_ST_V_LSB         = 12;
    localparam int SC_ST_V_MSB         = 22;
    localparam int SC_ST_RSVD_BIT      = 23;
    localparam int SC_ST_STAB_LSB      = 24;
    localparam int SC_ST_STAB_MSB      = 27;
    localparam int SC_ST_VLOST_BIT     = 28;
    localparam int SC_ST_HLOST_BIT     = 29;
    localparam int SC_ST_INTERLACE_BIT = 30;
    localparam int SC_ST_STABLE_BIT    = 31;

    // Saturating increment of the stability counter.
    function automatic logic [SC_STAB_CNT_W-1:0] sc_stab_inc(input logic [SC_STAB_CNT_W-1:0] cnt);
        logic [SC_STAB_CNT_W-1:0] one;
        one = {{(SC_STAB_CNT_W-1){1'b0}}, 1'b1};
        return (&cnt) ? cnt : cnt + one;
    endfunction

endpackage

// File: rtl/sc_sync_edge_det.sv
// rtl/sc_sync_edge_det.sv - two-flop sync register with leading-edge pulse
// Ports:
//   clk_i  : sample clock
//   rst_i  : asynchronous active-high reset
//   sync_i : active-high sync, synchronous to clk_i
//   edge_o : one-cycle pulse on the 0->1 transition (q & ~qq)
module sc_sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic edge_o
);

    logic q;
    logic qq;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q  <= 1'b0;
            qq <= 1'b0;
        end else begin
            q  <= sync_i;
            qq <= q;
        end
    end

    assign edge_o = q & ~qq;

endmodule

// File: rtl/sc_timing_meas.sv
// rtl/sc_timing_meas.sv - video sync timing measurement and status word generation
// Ports:
//   clk_i, rst_i   : sample clock, asynchronous active-high reset
//   hsync_i        : normalized active-high hsync
//   vsync_i        : normalized active-high vsync
//   h_total_o      : clocks per line (0 while not measured)
//   v_total_o      : lines per field (larger field when interlaced)
//   interlace_o    : interlaced source detected
//   hsync_lost_o   : hsync timeout
//   vsync_lost_o   : vsync timeout
//   stable_o       : timing stable for STABLE_FRAMES consecutive fields
//   sc_status_o    : packed status word
module sc_timing_meas
    import sc_timing_pkg::*;
#(
    parameter int H_CNT_W       = 12,
    parameter int V_CNT_W       = 11,
    parameter int H_TOL         = 2,
    parameter int STABLE_FRAMES = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    output logic [H_CNT_W-1:0] h_total_o,
    output logic [V_CNT_W-1:0] v_total_o,
    output logic               interlace_o,
    output logic               hsync_lost_o,
    output logic               vsync_lost_o,
    output logic               stable_o,
    output logic [31:0]        sc_status_o
);

    localparam logic [H_CNT_W-1:0]       H_MAX    = '1;
    localparam logic [H_CNT_W-1:0]       H_ONE    = {{(H_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [H_CNT_W-1:0]       H_TOL_L  = H_TOL[H_CNT_W-1:0];
    localparam logic [V_CNT_W-1:0]       V_MAX    = '1;
    localparam logic [V_CNT_W-1:0]       V_ONE    = {{(V_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [V_CNT_W:0]         V_ONE_X  = {{V_CNT_W{1'b0}}, 1'b1};
    localparam logic [SC_STAB_CNT_W-1:0] STAB_THR = STABLE_FRAMES[SC_STAB_CNT_W-1:0];

    logic hs_edge;
    logic vs_edge;

    sc_sync_edge_det u_hs_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sync_i (hsync_i),
        .edge_o (hs_edge)
    );

    sc_sync_edge_det u_vs_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sync_i (vsync_i),
        .edge_o (vs_edge)
    );

    logic [H_CNT_W-1:0]       h_cnt;
    logic                     h_valid;
    logic [H_CNT_W-1:0]       h_ref;
    logic [V_CNT_W-1:0]       v_cnt;
    logic                     v_valid;
    logic [V_CNT_W-1:0]       v_prev;
    logic                     prev_valid;
    logic [SC_STAB_CNT_W-1:0] stab_cnt;

    logic h_sat;
    logic v_sat;
    logic h_loss;
    logic v_loss;

    // An arriving edge takes priority over a saturated counter: it ends
    // the timeout rather than extending it.
    assign h_sat  = (h_cnt == H_MAX);
    assign v_sat  = (v_cnt == V_MAX);
    assign h_loss = h_sat & ~hs_edge;
    // Any hsync loss also invalidates the line count.
    assign v_loss = (v_sat & ~vs_edge) | h_loss | hsync_lost_o;

    // Field capture evaluation, used only on a capturing vsync edge.
    logic [V_CNT_W:0]         v_cnt_x;
    logic [V_CNT_W:0]         v_prev_x;
    logic                     cap_int;
    logic [V_CNT_W-1:0]       cap_v;
    logic [H_CNT_W-1:0]       h_diff;
    logic                     cap_match;
    logic [SC_STAB_CNT_W-1:0] stab_next;

    assign v_cnt_x  = {1'b0, v_cnt};
    assign v_prev_x = {1'b0, v_prev};

    always_comb begin
        cap_int   = 1'b0;
        cap_v     = v_cnt;
        h_diff    = '0;
        cap_match = 1'b0;
        stab_next = '0;
        // Extended widths so that all-ones vs zero never reads as a difference of one.
        cap_int   = prev_valid &&
                    ((v_cnt_x == v_prev_x + V_ONE_X) || (v_prev_x == v_cnt_x + V_ONE_X));
        if (cap_int && (v_prev > v_cnt)) begin
            cap_v = v_prev;
        end
        h_diff    = (h_total_o >= h_ref) ? (h_total_o - h_ref) : (h_ref - h_total_o);
        cap_match = prev_valid && (h_diff <= H_TOL_L) &&
                    (cap_v == v_total_o) && (cap_int == interlace_o);
        stab_next = cap_match ? sc_stab_inc(stab_cnt) : '0;
    end

    // Horizontal period measurement.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt        <= '0;
            h_valid      <= 1'b0;
            h_total_o    <= '0;
            hsync_lost_o <= 1'b0;
        end else if (hs_edge) begin
            h_cnt        <= H_ONE;
            // A saturated count is not a real period.
            if (h_valid && !h_sat) begin
                h_total_o <= h_cnt;
            end
            h_valid      <= 1'b1;
            hsync_lost_o <= 1'b0;
        end else if (h_sat) begin
            hsync_lost_o <= 1'b1;
            h_total_o    <= '0;
            h_valid      <= 1'b0;
        end else begin
            h_cnt <= h_cnt + H_ONE;
        end
    end

    // Line counting, interlace detection and stability tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_cnt        <= '0;
            v_valid      <= 1'b0;
            v_prev       <= '0;
            prev_valid   <= 1'b0;
            v_total_o    <= '0;
            interlace_o  <= 1'b0;
            vsync_lost_o <= 1'b0;
            h_ref        <= '0;
            stab_cnt     <= '0;
            stable_o     <= 1'b0;
        end else begin
            // A coincident hsync edge is line 1 of the new field.
            if (vs_edge) begin
                v_cnt <= hs_edge ? V_ONE : '0;
            end else if (hs_edge && !v_sat) begin
                v_cnt <= v_cnt + V_ONE;
            end

            if (v_loss) begin
                vsync_lost_o <= 1'b1;
                v_total_o    <= '0;
                v_valid      <= 1'b0;
                prev_valid   <= 1'b0;
                interlace_o  <= 1'b0;
                stab_cnt     <= '0;
                stable_o     <= 1'b0;
            end else if (vs_edge) begin
                vsync_lost_o <= 1'b0;
                v_valid      <= 1'b1;
                if (v_valid) begin
                    v_total_o   <= cap_v;
                    interlace_o <= cap_int;
                    v_prev      <= v_cnt;
                    prev_valid  <= 1'b1;
                    h_ref       <= h_total_o;
                    stab_cnt    <= stab_next;
                    stable_o    <= (stab_next >= STAB_THR);
                end
            end
        end
    end

    // Status word: zero-extended fields over registered outputs.
    logic [SC_ST_H_MSB-SC_ST_H_LSB:0] h_ext;
    logic [SC_ST_V_MSB-SC_ST_V_LSB:0] v_ext;

    always_comb begin
        h_ext = '0;
        v_ext = '0;
        h_ext[H_CNT_W-1:0] = h_total_o;
        v_ext[V_CNT_W-1:0] = v_total_o;
        sc_status_o                                = '0;
        sc_status_o[SC_ST_H_MSB:SC_ST_H_LSB]       = h_ext;
        sc_status_o[SC_ST_V_MSB:SC_ST_V_LSB]       = v_ext;
        sc_status_o[SC_ST_RSVD_BIT]                = 1'b0;
        sc_status_o[SC_ST_STAB_MSB:SC_ST_STAB_LSB] = stab_cnt;
        sc_status_o[SC_ST_VLOST_BIT]               = vsync_lost_o;
        sc_status_o[SC_ST_HLOST_BIT]               = hsync_lost_o;
        sc_status_o[SC_ST_INTERLACE_BIT]           = interlace_o;
        sc_status_o[SC_ST_STABLE_BIT]              = stable_o;
    end

endmodule

// File: tb/tb_sc_timing_meas.sv
// tb/tb_sc_timing_meas.sv - scoreboard bench for sc_timing_meas
// Stimulus pushes the expected status word for every vsync edge it drives;
// a monitor pops and compares a few cycles after each edge.
module tb_sc_timing_meas;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        hsync_i;
    logic        vsync_i;
    logic [11:0] h_total_o;
    logic [10:0] v_total_o;
    logic        interlace_o;
    logic        hsync_lost_o;
    logic        vsync_lost_o;
    logic        stable_o;
    logic [31:0] sc_status_o;

    sc_timing_meas dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .hsync_i      (hsync_i),
        .vsync_i      (vsync_i),
        .h_total_o    (h_total_o),
        .v_total_o    (v_total_o),
        .interlace_o  (interlace_o),
        .hsync_lost_o (hsync_lost_o),
        .vsync_lost_o (vsync_lost_o),
        .stable_o     (stable_o),
        .sc_status_o  (sc_status_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic        mon_prev = 1'b0;
    int          mon_idx  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i   = 1'b1;
        hsync_i = 1'b0;
        vsync_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic run_line(input int period, input logic vs);
        for (int c = 0; c < period; c++) begin
            @(negedge clk_i);
            hsync_i = (c < 8);
            vsync_i = vs;
        end
    endtask

    // vsync rises together with hsync at the start of line 0.
    task automatic run_field(input int period, input int lines, input logic [31:0] exp);
        exp_q.push_back(exp);
        for (int l = 0; l < lines; l++) run_line(period, (l < 3));
    endtask

    task automatic prog_seq();
        run_field(80, 16, 32'h0000_0000);
        run_field(80, 16, 32'h0001_0050);
        run_field(80, 16, 32'h0101_0050);
        run_field(80, 16, 32'h0201_0050);
        run_field(80, 16, 32'h8301_0050);
    endtask

    task automatic wait_lost(output int n);
        n = 0;
        while (!hsync_lost_o && n < 6000) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    // Monitor: three cycles after each driven vsync rise, compare the status word.
    initial begin
        forever begin
            @(posedge clk_i);
            if (vsync_i && !mon_prev) begin
                mon_prev = 1'b1;
                repeat (3) @(posedge clk_i);
                @(negedge clk_i);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL vs_status_%0d: got 0x%08h expected no vsync edge", mon_idx, sc_status_o);
                end else begin
                    check($sformatf("vs_status_%0d", mon_idx), sc_status_o, exp_q.pop_front());
                end
                mon_idx++;
            end
            mon_prev = vsync_i;
        end
    end

    int      n_lost;
    int      per_tab[9] = '{80, 81, 80, 81, 80, 90, 90, 90, 90};
    logic [31:0] exp_tab[9] = '{32'h0000_0000, 32'h0001_0050, 32'h0101_0051, 32'h0201_0050,
                                32'h8301_0051, 32'h8401_0050, 32'h0001_005A, 32'h0101_005A,
                                32'h0201_005A};

    initial begin
        rst_i   = 1'b1;
        hsync_i = 1'b0;
        vsync_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset_status", sc_status_o, 32'h0);
        check("reset_outs", 32'({h_total_o, v_total_o, interlace_o, hsync_lost_o, vsync_lost_o, stable_o}), 32'h0);

        // No sync at all: both timeouts after the h counter saturates.
        rst_i = 1'b0;
        wait_lost(n_lost);
        check_range("nosync_lost_cycles", n_lost, 4090, 4100);
        check("nosync_status", sc_status_o, 32'h3000_0000);

        // Progressive 80 x 16.
        do_reset();
        prog_seq();
        run_field(80, 1, 32'h8401_0050);
        check("prog_h_total", 32'(h_total_o), 32'd80);
        check("prog_v_total", 32'(v_total_o), 32'd16);
        check("prog_flags", 32'({interlace_o, stable_o}), 32'b01);

        // Interlaced 86 x alternating 12/13.
        do_reset();
        run_field(86, 12, 32'h0000_0000);
        run_field(86, 13, 32'h0000_C056);
        run_field(86, 12, 32'h4000_D056);
        run_field(86, 13, 32'h4100_D056);
        run_field(86, 12, 32'h4200_D056);
        run_field(86, 1, 32'hC300_D056);
        check("intl_flags", 32'({interlace_o, stable_o}), 32'b11);

        // Jitter within tolerance, then a step outside it.
        do_reset();
        for (int i = 0; i < 9; i++) run_field(per_tab[i], 16, exp_tab[i]);
        run_field(90, 1, 32'h8301_005A);

        // Hsync and vsync removed mid-field, then resumed.
        do_reset();
        prog_seq();
        run_field(80, 10, 32'h8401_0050);
        hsync_i = 1'b0;
        vsync_i = 1'b0;
        check("loss_pre_stable", 32'(stable_o), 32'd1);
        wait_lost(n_lost);
        check_range("loss_cycles", n_lost, 4008, 4028);
        check("loss_status", sc_status_o, 32'h3000_0000);
        run_line(80, 1'b0);
        check("resume_line1", 32'({hsync_lost_o, h_total_o}), 32'h0);
        run_line(80, 1'b0);
        check("resume_line2_h", 32'(h_total_o), 32'd80);
        check("resume_vlost_held", 32'(vsync_lost_o), 32'd1);
        run_field(80, 16, 32'h0000_0050);
        run_field(80, 16, 32'h0001_0050);
        run_field(80, 1, 32'h0101_0050);

        // Asynchronous reset mid-field, then full re-acquisition.
        do_reset();
        run_field(80, 16, 32'h0000_0000);
        run_field(80, 16, 32'h0001_0050);
        run_field(80, 16, 32'h0101_0050);
        run_field(80, 6, 32'h0201_0050);
        @(negedge clk_i);
        #2;
        rst_i   = 1'b1;
        hsync_i = 1'b0;
        vsync_i = 1'b0;
        #1;
        check("midreset_status", sc_status_o, 32'h0);
        check("midreset_outs", 32'({h_total_o, v_total_o, interlace_o, hsync_lost_o, vsync_lost_o, stable_o}), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        prog_seq();
        run_field(80, 1, 32'h8401_0050);

        repeat (10) @(negedge clk_i);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sc_timing_meas.md
# sc_timing_meas

Measures incoming video sync timing in the sample-clock domain and produces the status word read by software through the scan converter config block's `sc_status_i` input. It sits directly upstream of that block, between the sync slicer (normalized active-high hsync/vsync) and the Avalon register file. It reports:

- horizontal period in clocks;
- lines per field;
- interlace;
- sync loss;
- a frame-stability qualifier used by firmware to trigger mode detection.

## Interface

Parameters:
- `H_CNT_W`, default 12: horizontal counter width, ≤12.
- `V_CNT_W`, default 11: line counter width, ≤11.
- `H_TOL`, default 2: allowed h_total deviation, in clocks, between fields still counted as stable.
- `STABLE_FRAMES`, default 3: number of consecutive matching fields required before `stable_o` asserts, 1..15.

Ports:
- `clk_i` in 1: sample clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `hsync_i` in 1: normalized hsync, active-high, synchronous to `clk_i`.
- `vsync_i` in 1: normalized vsync, active-high, synchronous to `clk_i`.
- `h_total_o` out H_CNT_W: clocks per line.
- `v_total_o` out V_CNT_W: lines per field; for interlaced sources, the larger of the two fields.
- `interlace_o` out 1: interlaced source detected.
- `hsync_lost_o` out 1: hsync timeout.
- `vsync_lost_o` out 1: vsync timeout.
- `stable_o` out 1: timing stable.
- `sc_status_o` out 32: packed status word.

## Operation

Edge detection:
- Inputs are registered twice (`q`, `qq`).
- A leading edge is `q & ~qq`; `hs_edge` and `vs_edge` are each 1 cycle wide.

Horizontal counting:
- `h_cnt` increments every cycle and saturates at all-ones.
- On `hs_edge`: `h_cnt <= 1`, and `h_total_o <= h_cnt` if `h_valid`; then `h_valid <= 1`.
- The first edge after reset or after loss is discarded.
- If `h_cnt` reaches all-ones: `hsync_lost_o = 1`, `h_total_o = 0`, `h_valid = 0`, stability count cleared.
- `hsync_lost_o` is cleared at the next `hs_edge`.

Line counting:
- `v_cnt` increments on `hs_edge` and saturates at all-ones.
- On `vs_edge`: capture `v_cnt` as the current field count if `v_valid`; then `v_cnt <= hs_edge ? 1 : 0`. A simultaneous hsync edge counts as line 1 of the new field.
- The first `vs_edge` after reset or after loss only sets `v_valid`.
- Saturation of `v_cnt`, or `hsync_lost_o`, sets `vsync_lost_o = 1`, `v_total_o = 0`, `v_valid = 0`, `interlace_o = 0`, and clears the stability count. `vsync_lost_o` is cleared at the next `vs_edge`.

Interlace (on each capturing `vs_edge`):
- `interlace_o <= prev_valid && |cur − prev| == 1`.
- `v_total_o <= interlace ? max(cur, prev) : cur`.
- `prev <= cur`, `prev_valid <= 1`.

Stability (on each capturing `vs_edge`):
- The new values match when |new h_total − h_ref| ≤ H_TOL, and new `v_total_o` equals the old one, and new `interlace_o` equals the old one.
- On a match, `stab_cnt` increments, saturating at 15; otherwise `stab_cnt <= 0`. The first capture has no reference and is treated as a mismatch.
- `h_ref <= h_total_o` on every capture.
- `stable_o = (stab_cnt >= STABLE_FRAMES)`; it is cleared in the same cycle as any loss flag.

`sc_status_o` packing (unused bits are 0; narrower fields are zero-extended):

| Bits | Field |
|---|---|
| [11:0] | `h_total` |
| [22:12] | `v_total` |
| [23] | 0 |
| [27:24] | `stab_cnt` |
| [28] | `vsync_lost` |
| [29] | `hsync_lost` |
| [30] | `interlace` |
| [31] | `stable` |

## Timing

- Reset: every output and internal register is 0.
- Latency: an input edge sampled at clock edge k produces `hs_edge`/`vs_edge` in cycle k+1. Captured values are visible after clock edge k+2.
- The h period measured equals the exact clock count between consecutive leading edges.
- Stability and interlace outputs are updated in the same cycle as `v_total_o`.
- All outputs are registered; `sc_status_o` is a wire concatenation of registered outputs.
- Reset asserted mid-field returns the block to the discard-first-edge state.

## Structure

- Package `sc_timing_pkg` holds:
  - status bit-position constants (`SC_ST_STABLE_BIT` etc.) and field LSB/MSB constants;
  - `stab_cnt` width;
  - the max H/V widths (12/11).
- One sub-module, `sc_sync_edge_det`: a 2-flop register plus leading-edge pulse generator, instantiated for hsync and vsync.

## Test plan

1. Reset, no sync: all outputs 0; after 4095 cycles, `hsync_lost_o = 1` and `vsync_lost_o = 1`.
2. Progressive, 800 clk/line × 525 lines:
   - `h_total_o = 800` and `v_total_o = 525` after the 2nd vsync edge;
   - `interlace_o = 0`;
   - `stable_o` rises at the 5th vsync edge; `sc_status_o` is 0x8320_D320.
3. Interlaced, 858 × alternating 262/263-line fields: `interlace_o = 1` from the 3rd vsync edge, `v_total_o = 263`, `stable_o` rises at the 6th vsync edge.
4. Jitter and jump:
   - hsync period alternating 800/801 keeps `stable_o = 1`;
   - a step to 810 clears `stable_o` at the next vsync edge;
   - `stable_o` re-asserts 3 fields later.
5. Hsync removed mid-field: after 4095 idle cycles, `hsync_lost_o = 1`, `stable_o = 0`, `h_total_o = 0`. Sync resumes → first valid `h_total_o` after the 2nd hsync edge.
6. Edge cases:
   - vsync and hsync edges in the same cycle → the line is counted in the new field (`v_total_o` unchanged at 525);
   - `rst_i` pulsed mid-field → all outputs 0, then the full re-acquisition sequence repeats.
